// File: rtl/nios2_cpu_mul_seq.sv
// Sequences a shared 16x16 three-product multiplier cell over two passes to form a 64-bit product.
// Latency: done 4 cycles after accept (3 for MUL with EARLY_MUL); start is ignored while busy, not queued.
module nios2_cpu_mul_seq #(
  parameter bit SIGNED_SUPPORT = 1'b1,
  parameter bit EARLY_MUL      = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  output logic        mul_en,
  input  logic [31:0] mul_p1,
  input  logic [31:0] mul_p2,
  input  logic [31:0] mul_p3
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_CAP  = 3'd3,
    S_WAIT = 3'd4,
    S_ACC  = 3'd5
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  op_q;
  logic [31:0] p1_q;
  logic [31:0] p2_q;
  logic [31:0] p3_q;
  logic [31:0] p4_q;

  logic        accept;
  logic [1:0]  op_eff;
  logic        mul_en_d;
  logic [31:0] mul_src1_d;
  logic [31:0] mul_src2_d;
  logic        cap_lo;
  logic        cap_hi;
  logic        fin;

  logic [32:0] mid;
  logic [32:0] lo_sum;
  logic [31:0] hi_u;
  logic [31:0] corr_a;
  logic [31:0] corr_b;
  logic [31:0] result_d;

  assign ready  = (state_q == S_IDLE);
  assign accept = ready && start;
  // Without signed support the signed high-word ops collapse onto MULXUU at accept time.
  assign op_eff = (!SIGNED_SUPPORT && op[1]) ? OP_MULXUU : op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_LO;
      S_LO:   state_d = (EARLY_MUL && (op_q == OP_MUL)) ? S_WAIT : S_HI;
      S_HI:   state_d = S_CAP;
      S_CAP:  state_d = S_ACC;
      S_WAIT: state_d = S_ACC;
      S_ACC:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Cell-facing outputs are registered, so they are computed for the state being entered.
  always_comb begin
    mul_en_d   = 1'b0;
    mul_src1_d = mul_src1;
    mul_src2_d = mul_src2;
    cap_lo     = 1'b0;
    cap_hi     = 1'b0;
    fin        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mul_en_d   = 1'b1;
          mul_src1_d = src1;
          mul_src2_d = src2;
        end
      end
      S_LO: begin
        if (state_d == S_HI) begin
          mul_en_d   = 1'b1;
          mul_src1_d = {16'h0000, a_q[31:16]};
          mul_src2_d = {16'h0000, b_q[31:16]};
        end
      end
      S_HI:   cap_lo = 1'b1;
      S_WAIT: cap_lo = 1'b1;
      S_CAP:  cap_hi = 1'b1;
      S_ACC:  fin    = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    mid    = {1'b0, p2_q} + {1'b0, p3_q};
    lo_sum = {1'b0, p1_q} + {1'b0, mid[15:0], 16'h0000};
    hi_u   = p4_q + {15'h0000, mid[32:16]} + {31'h0, lo_sum[32]};
    corr_a = a_q[31] ? b_q : 32'h0;
    corr_b = b_q[31] ? a_q : 32'h0;
    case (op_q)
      OP_MUL:    result_d = lo_sum[31:0];
      OP_MULXUU: result_d = hi_u;
      OP_MULXSU: result_d = hi_u - corr_a;
      OP_MULXSS: result_d = hi_u - corr_a - corr_b;
      default:   result_d = hi_u;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      op_q     <= 2'b00;
      p1_q     <= 32'h0;
      p2_q     <= 32'h0;
      p3_q     <= 32'h0;
      p4_q     <= 32'h0;
      mul_en   <= 1'b0;
      mul_src1 <= 32'h0;
      mul_src2 <= 32'h0;
      done     <= 1'b0;
      result   <= 32'h0;
    end else begin
      mul_en   <= mul_en_d;
      mul_src1 <= mul_src1_d;
      mul_src2 <= mul_src2_d;
      done     <= fin;
      if (accept) begin
        a_q  <= src1;
        b_q  <= src2;
        op_q <= op_eff;
      end
      if (cap_lo) begin
        p1_q <= mul_p1;
        p2_q <= mul_p2;
        p3_q <= mul_p3;
      end
      if (cap_hi) begin
        p4_q <= mul_p1;
      end
      if (fin) begin
        result <= result_d;
      end
    end
  end

endmodule

// File: tb/tb_nios2_cpu_mul_seq.sv
// Directed bench for nios2_cpu_mul_seq: default instance plus an unsigned, no-early-MUL instance.
module tb_nios2_cpu_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start0, start1;
  logic [1:0]  op;
  logic [31:0] src1, src2;

  logic        ready0, done0, men0;
  logic [31:0] result0, ms1_0, ms2_0, p1_0, p2_0, p3_0;
  logic        ready1, done1, men1;
  logic [31:0] result1, ms1_1, ms2_1, p1_1, p2_1, p3_1;

  int total = 0;
  int bad   = 0;

  nios2_cpu_mul_seq #(.SIGNED_SUPPORT(1'b1), .EARLY_MUL(1'b1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .op(op), .src1(src1), .src2(src2),
    .ready(ready0), .done(done0), .result(result0),
    .mul_src1(ms1_0), .mul_src2(ms2_0), .mul_en(men0),
    .mul_p1(p1_0), .mul_p2(p2_0), .mul_p3(p3_0)
  );

  nios2_cpu_mul_seq #(.SIGNED_SUPPORT(1'b0), .EARLY_MUL(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .op(op), .src1(src1), .src2(src2),
    .ready(ready1), .done(done1), .result(result1),
    .mul_src1(ms1_1), .mul_src2(ms2_1), .mul_en(men1),
    .mul_p1(p1_1), .mul_p2(p2_1), .mul_p3(p3_1)
  );

  // Registered three-product multiplier cells, one per instance.
  always_ff @(posedge clk) begin
    if (men0) begin
      p1_0 <= {16'h0, ms1_0[15:0]}  * {16'h0, ms2_0[15:0]};
      p2_0 <= {16'h0, ms1_0[15:0]}  * {16'h0, ms2_0[31:16]};
      p3_0 <= {16'h0, ms1_0[31:16]} * {16'h0, ms2_0[15:0]};
    end
  end
  always_ff @(posedge clk) begin
    if (men1) begin
      p1_1 <= {16'h0, ms1_1[15:0]}  * {16'h0, ms2_1[15:0]};
      p2_1 <= {16'h0, ms1_1[15:0]}  * {16'h0, ms2_1[31:16]};
      p3_1 <= {16'h0, ms1_1[31:16]} * {16'h0, ms2_1[15:0]};
    end
  end

  // Issues one op on the selected instance; lat counts edges from accept to done (-1 on timeout).
  task automatic do_op(input bit sel, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    op = o; src1 = a; src2 = b;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    lat = -1;
    res = 32'hDEAD_BEEF;
    for (int k = 0; k < 20; k++) begin
      if (sel ? done1 : done0) begin
        lat = k;
        res = sel ? result1 : result0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #1;
    total++; if (ready0 !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready0); end
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done0); end
    total++; if (result0 !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result0); end
    total++; if (men0 !== 1'b0) begin bad++; $display("FAIL reset_mul_en got=%b want=0", men0); end
    total++; if ({ms1_0, ms2_0} !== 64'h0) begin bad++; $display("FAIL reset_mul_src got=%h/%h want=0", ms1_0, ms2_0); end
    total++; if (ready1 !== 1'b1) begin bad++; $display("FAIL reset_ready1 got=%b want=1", ready1); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_cell_drive;
    int lat;
    @(negedge clk);
    op = 2'b01; src1 = 32'h0001_0002; src2 = 32'h0003_0004; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    total++; if (men0 !== 1'b1 || ms1_0 !== 32'h0001_0002 || ms2_0 !== 32'h0003_0004) begin
      bad++; $display("FAIL lo_drive got en=%b a=%h b=%h want en=1 a=00010002 b=00030004", men0, ms1_0, ms2_0); end
    total++; if (ready0 !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b want=0", ready0); end
    @(negedge clk);
    total++; if (men0 !== 1'b1 || ms1_0 !== 32'h0000_0001 || ms2_0 !== 32'h0000_0003) begin
      bad++; $display("FAIL hi_drive got en=%b a=%h b=%h want en=1 a=00000001 b=00000003", men0, ms1_0, ms2_0); end
    @(negedge clk);
    total++; if (men0 !== 1'b0 || ms1_0 !== 32'h0000_0001) begin
      bad++; $display("FAIL cap_hold got en=%b a=%h want en=0 a=00000001", men0, ms1_0); end
    lat = -1;
    for (int k = 2; k < 20; k++) begin
      if (done0) begin lat = k; break; end
      @(negedge clk);
    end
    total++; if (lat != 4 || result0 !== 32'h0000_0003) begin
      bad++; $display("FAIL cell_mulxuu got lat=%0d res=%h want lat=4 res=00000003", lat, result0); end
    @(negedge clk);
    total++; if (done0 !== 1'b0 || result0 !== 32'h0000_0003) begin
      bad++; $display("FAIL done_pulse got done=%b res=%h want done=0 res=00000003", done0, result0); end
  endtask

  task automatic test_mul_basic;
    logic [31:0] res; int lat;
    do_op(1'b0, 2'b00, 32'h0001_0002, 32'h0003_0004, res, lat);
    total++; if (res !== 32'h000A_0008) begin bad++; $display("FAIL mul_basic got=%h want=000a0008", res); end
    total++; if (lat != 3) begin bad++; $display("FAIL mul_early_lat got=%0d want=3", lat); end
    do_op(1'b0, 2'b01, 32'h0001_0002, 32'h0003_0004, res, lat);
    total++; if (res !== 32'h0000_0003) begin bad++; $display("FAIL mulxuu_basic got=%h want=00000003", res); end
    total++; if (lat != 4) begin bad++; $display("FAIL mulxuu_lat got=%0d want=4", lat); end
  endtask

  task automatic test_all_ones;
    logic [31:0] res; int lat;
    do_op(1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    total++; if (res !== 32'hFFFF_FFFE) begin bad++; $display("FAIL ones_mulxuu got=%h want=fffffffe", res); end
    do_op(1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    total++; if (res !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ones_mulxsu got=%h want=ffffffff", res); end
    do_op(1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    total++; if (res !== 32'h0000_0000) begin bad++; $display("FAIL ones_mulxss got=%h want=00000000", res); end
    total++; if (lat != 4) begin bad++; $display("FAIL ones_mulxss_lat got=%0d want=4", lat); end
  endtask

  task automatic test_carry;
    logic [31:0] res; int lat;
    do_op(1'b0, 2'b00, 32'h8000_0000, 32'h0000_0002, res, lat);
    total++; if (res !== 32'h0000_0000) begin bad++; $display("FAIL carry_mul got=%h want=00000000", res); end
    do_op(1'b0, 2'b01, 32'h8000_0000, 32'h0000_0002, res, lat);
    total++; if (res !== 32'h0000_0001) begin bad++; $display("FAIL carry_mulxuu got=%h want=00000001", res); end
    do_op(1'b0, 2'b01, 32'h0001_FFFF, 32'h0001_FFFF, res, lat);
    total++; if (res !== 32'h0000_0003) begin bad++; $display("FAIL carry_lo_word got=%h want=00000003", res); end
  endtask

  task automatic test_signed;
    logic [31:0] res; int lat;
    do_op(1'b0, 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, res, lat);
    total++; if (res !== 32'hFFFF_FFFA) begin bad++; $display("FAIL neg_mul got=%h want=fffffffa", res); end
    do_op(1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0000_0003, res, lat);
    total++; if (res !== 32'hFFFF_FFFF) begin bad++; $display("FAIL neg_mulxsu got=%h want=ffffffff", res); end
    do_op(1'b0, 2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFFD, res, lat);
    total++; if (res !== 32'h0000_0000) begin bad++; $display("FAIL negneg_mulxss got=%h want=00000000", res); end
    do_op(1'b0, 2'b11, 32'h8000_0000, 32'h8000_0000, res, lat);
    total++; if (res !== 32'h4000_0000) begin bad++; $display("FAIL min_mulxss got=%h want=40000000", res); end
    do_op(1'b0, 2'b10, 32'h8000_0000, 32'h8000_0000, res, lat);
    total++; if (res !== 32'hC000_0000) begin bad++; $display("FAIL min_mulxsu got=%h want=c0000000", res); end
  endtask

  task automatic test_no_signed;
    logic [31:0] res; int lat;
    do_op(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    total++; if (res !== 32'hFFFF_FFFE) begin bad++; $display("FAIL nosign_mulxss got=%h want=fffffffe", res); end
    do_op(1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    total++; if (res !== 32'hFFFF_FFFE) begin bad++; $display("FAIL nosign_mulxsu got=%h want=fffffffe", res); end
    do_op(1'b1, 2'b00, 32'h0001_0002, 32'h0003_0004, res, lat);
    total++; if (res !== 32'h000A_0008) begin bad++; $display("FAIL noearly_mul got=%h want=000a0008", res); end
    total++; if (lat != 4) begin bad++; $display("FAIL noearly_mul_lat got=%0d want=4", lat); end
  endtask

  task automatic test_handshake;
    int dn, first, second;
    logic [31:0] r1, r2;
    dn = 0; first = -1; second = -1; r1 = 32'h0; r2 = 32'h0;
    @(negedge clk);
    op = 2'b01; src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF; start0 = 1'b1;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      if (k == 1) begin
        src1 = 32'h8000_0000;
        total++; if (ready0 !== 1'b0) begin bad++; $display("FAIL hs_busy_ready got=%b want=0", ready0); end
      end
      if (k == 9) start0 = 1'b0;
      if (done0) begin
        dn++;
        if (dn == 1) begin first = k; r1 = result0; end
        else if (dn == 2) begin second = k; r2 = result0; end
      end
    end
    total++; if (dn != 2) begin bad++; $display("FAIL hs_done_count got=%0d want=2", dn); end
    total++; if (first != 4 || second != 9) begin bad++; $display("FAIL hs_done_cycles got=%0d,%0d want=4,9", first, second); end
    total++; if (r1 !== 32'hFFFF_FFFE) begin bad++; $display("FAIL hs_latched_a got=%h want=fffffffe", r1); end
    total++; if (r2 !== 32'h7FFF_FFFF) begin bad++; $display("FAIL hs_second got=%h want=7fffffff", r2); end
  endtask

  task automatic test_reset_midop;
    int dn;
    dn = 0;
    @(negedge clk);
    op = 2'b00; src1 = 32'h0001_0002; src2 = 32'h0003_0004; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    total++; if (ready0 !== 1'b1 || result0 !== 32'h0 || men0 !== 1'b0) begin
      bad++; $display("FAIL midop_reset got ready=%b res=%h en=%b want ready=1 res=0 en=0", ready0, result0, men0); end
    total++; if (ms1_0 !== 32'h0 || ms2_0 !== 32'h0) begin
      bad++; $display("FAIL midop_mul_src got=%h/%h want=0/0", ms1_0, ms2_0); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) reset_n = 1'b1;
      if (done0) dn++;
    end
    total++; if (dn != 0 || result0 !== 32'h0) begin
      bad++; $display("FAIL midop_no_done got dones=%0d res=%h want 0/0", dn, result0); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  ops [3];
    logic [31:0] as  [3];
    logic [31:0] bs  [3];
    logic [31:0] exp [3];
    int idx, last;
    ops[0] = 2'b01; as[0] = 32'h0001_0002; bs[0] = 32'h0003_0004; exp[0] = 32'h0000_0003;
    ops[1] = 2'b10; as[1] = 32'hFFFF_FFFE; bs[1] = 32'h0000_0003; exp[1] = 32'hFFFF_FFFF;
    ops[2] = 2'b11; as[2] = 32'hFFFF_FFFE; bs[2] = 32'hFFFF_FFFD; exp[2] = 32'h0000_0000;
    idx = 0; last = -1;
    @(negedge clk);
    op = ops[0]; src1 = as[0]; src2 = bs[0]; start0 = 1'b1;
    for (int k = 0; k < 40 && idx < 3; k++) begin
      @(negedge clk);
      if (done0) begin
        total++; if (result0 !== exp[idx]) begin
          bad++; $display("FAIL b2b_result%0d got=%h want=%h", idx, result0, exp[idx]); end
        total++; if (k - last != ((idx == 0) ? 5 : 5)) begin
          bad++; $display("FAIL b2b_spacing%0d got=%0d want=5", idx, k - last); end
        last = k;
        idx++;
        if (idx < 3) begin op = ops[idx]; src1 = as[idx]; src2 = bs[idx]; end
        else start0 = 1'b0;
      end
    end
    start0 = 1'b0;
    total++; if (idx != 3) begin bad++; $display("FAIL b2b_complete got=%0d want=3", idx); end
  endtask

  initial begin
    reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    op = 2'b00; src1 = 32'h0; src2 = 32'h0;
    test_reset;
    test_cell_drive;
    test_mul_basic;
    test_all_ones;
    test_carry;
    test_signed;
    test_no_signed;
    test_handshake;
    test_reset_midop;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
